// File: rtl/decim_multimode.sv
// Runtime-configurable decimator: plain decimation, boxcar average or min/max
// peak detect over windows of 2^k accepted samples, with window restart.
module decim_multimode #(
    parameter int BITS_ADC  = 8,
    parameter int MAX_K     = 4,
    parameter int BITS_ACUM = BITS_ADC + MAX_K
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(MAX_K+1)-1:0]   k,
    input  logic [1:0]                   mode,
    input  logic                         restart,
    input  logic [BITS_ADC-1:0]          sample_in,
    input  logic                         rdy_in,
    output logic [BITS_ADC-1:0]          sample_out,
    output logic [BITS_ADC-1:0]          sample_aux_out,
    output logic [1:0]                   mode_out,
    output logic                         rdy_out
);
    localparam int KW = $clog2(MAX_K + 1);
    localparam int CW = MAX_K + 1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [1:0]            mode_q, mode_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BITS_ACUM-1:0]  acc_q, acc_d;
    logic [BITS_ADC-1:0]   first_q, first_d;
    logic [BITS_ADC-1:0]   min_q, min_d;
    logic [BITS_ADC-1:0]   max_q, max_d;
    logic [BITS_ADC-1:0]   out_q, out_d;
    logic [BITS_ADC-1:0]   aux_q, aux_d;
    logic [1:0]            mode_out_q, mode_out_d;
    logic                  rdy_out_q, rdy_out_d;

    logic [KW-1:0]         k_eff, k_win;
    logic [1:0]            mode_eff, mode_win;
    logic                  open_win, last;
    logic [CW-1:0]         cnt_cur, df_m1;
    logic [BITS_ACUM-1:0]  acc_sum;
    logic [BITS_ADC-1:0]   first_cur, min_cur, max_cur, mean;

    always_comb begin
        k_eff     = (k > KW'(MAX_K)) ? KW'(MAX_K) : k;
        mode_eff  = (mode == 2'd3) ? 2'd0 : mode;
        // A restart with a coincident sample opens a fresh window on that sample.
        open_win  = rdy_in && (restart || state_q == IDLE);
        k_win     = open_win ? k_eff : k_q;
        mode_win  = open_win ? mode_eff : mode_q;
        cnt_cur   = open_win ? '0 : cnt_q;
        df_m1     = (CW'(1) << k_win) - CW'(1);
        last      = rdy_in && (cnt_cur == df_m1);
        acc_sum   = (open_win ? '0 : acc_q) + BITS_ACUM'(sample_in);
        first_cur = open_win ? sample_in : first_q;
        min_cur   = (open_win || sample_in < min_q) ? sample_in : min_q;
        max_cur   = (open_win || sample_in > max_q) ? sample_in : max_q;
        mean      = BITS_ADC'(acc_sum >> k_win);

        state_d    = state_q;
        k_d        = k_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        first_d    = first_q;
        min_d      = min_q;
        max_d      = max_q;
        out_d      = out_q;
        aux_d      = aux_q;
        mode_out_d = mode_out_q;
        rdy_out_d  = last;

        if (restart) begin
            state_d = IDLE;
        end
        if (rdy_in) begin
            state_d = last ? IDLE : ACC;
            k_d     = k_win;
            mode_d  = mode_win;
            cnt_d   = cnt_cur + CW'(1);
            acc_d   = acc_sum;
            first_d = first_cur;
            min_d   = min_cur;
            max_d   = max_cur;
        end
        if (last) begin
            mode_out_d = mode_win;
            case (mode_win)
                2'd1: begin
                    out_d = mean;
                    aux_d = mean;
                end
                2'd2: begin
                    out_d = min_cur;
                    aux_d = max_cur;
                end
                default: begin
                    out_d = first_cur;
                    aux_d = first_cur;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            mode_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            first_q    <= '0;
            min_q      <= '0;
            max_q      <= '0;
            out_q      <= '0;
            aux_q      <= '0;
            mode_out_q <= '0;
            rdy_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            min_q      <= min_d;
            max_q      <= max_d;
            out_q      <= out_d;
            aux_q      <= aux_d;
            mode_out_q <= mode_out_d;
            rdy_out_q  <= rdy_out_d;
        end
    end

    assign sample_out     = out_q;
    assign sample_aux_out = aux_q;
    assign mode_out       = mode_out_q;
    assign rdy_out        = rdy_out_q;
endmodule

// File: doc/decim_multimode.md
Name: decim_multimode

Overview:
- Parametrised, runtime-configurable decimator between the ADC sample stream and the acquisition buffer.
- Generalises the plain averaging decimator with:
  - three selectable modes: plain decimation, boxcar average, min/max peak detect;
  - a clamped decimation exponent;
  - config latched per window;
  - a synchronous window-restart input for trigger alignment.
- Consumes one sample per rdy_in strobe. Emits one result, with a one-cycle rdy_out pulse, per 2^k accepted samples.

Parameters:
- BITS_ADC, 8, sample width.
- MAX_K, 4, maximum decimation exponent (max DF = 2^MAX_K = 16).
- BITS_ACUM, BITS_ADC+MAX_K, accumulator width; must be ≥ BITS_ADC+MAX_K.

Ports:
- clk  input  1  fpga clock.
- rst  input  1  synchronous, active-high reset.
- k  input  $clog2(MAX_K+1)  decimation exponent, DF = 2^k; values > MAX_K clamp to MAX_K.
- mode  input  2  0 = decimate, 1 = average, 2 = peak, 3 = treated as 0.
- restart  input  1  synchronous window restart.
- sample_in  input  BITS_ADC  input sample.
- rdy_in  input  1  sample valid strobe.
- sample_out  output  BITS_ADC  result: first sample (mode 0), mean (mode 1), minimum (mode 2).
- sample_aux_out  output  BITS_ADC  maximum in mode 2; equals sample_out in modes 0/1.
- mode_out  output  2  effective mode of the emitted result.
- rdy_out  output  1  one-cycle result strobe.

Behaviour:
- Reset state:
  - all outputs 0;
  - count, acc, min, max cleared;
  - window state IDLE (next accepted sample opens a window);
  - k and mode latched at the next window open.
- Window FSM states:
  - IDLE → ACC on an accepted sample.
  - ACC → ACC while the count of samples in the window < DF.
  - On the DF-th sample: emit a result; next state is IDLE.
  - DF = 1 (k = 0): every sample opens and closes a window in the same cycle, i.e. pass-through with 1-cycle latency.
- Config latching:
  - k (clamped) and mode are sampled only on the cycle a window opens.
  - Changes mid-window take effect at the next window; the current window completes with its latched values.
- Samples:
  - Only cycles with rdy_in = 1 count.
  - Gaps of any length between strobes are allowed; state holds during gaps.
- Mode 0: result = first sample of the window; the remaining DF-1 samples are discarded.
- Mode 1:
  - acc accumulates zero-extended samples.
  - result = (acc + last sample) >> k_latched, truncated, never rounded.
  - No overflow is possible for any k ≤ MAX_K.
- Mode 2:
  - Running unsigned min/max, initialised from the first sample of the window.
  - sample_out = min, sample_aux_out = max.
- Output timing:
  - The result registers update and rdy_out = 1 on the clock edge after the cycle carrying the window's final rdy_in.
  - rdy_out is high for exactly one cycle.
  - sample_out / sample_aux_out / mode_out hold their value until the next result; they are not zeroed between strobes.
- restart = 1:
  - discards any partial window, returns to IDLE, no rdy_out for the discarded window;
  - if rdy_in is also 1 in the same cycle, that sample opens a new window with freshly latched config.
- rst = 1 overrides restart and rdy_in: the partial window is discarded and a pending result is not emitted.
- rst mid-window: no output for that window; the first post-reset window starts at the first accepted sample.
- Throughput: one sample per clock sustained, no backpressure, no internal stall.

Test Plan:
- k=2, mode=1, samples 10, 20, 30, 40 back-to-back → one rdy_out pulse 1 cycle after 40, sample_out=25, mode_out=1.
- k=4, mode=1, 16 samples of 255 with random rdy_in gaps → sample_out=255, no overflow; exactly one pulse.
- k=2, mode=2, samples 5, 200, 7, 100 → sample_out=5, sample_aux_out=200; next window 9, 9, 9, 9 → 9/9.
- k=3, mode=0, samples 1..16 → two pulses with sample_out=1 then 9; k=0 with 3, 4, 5 → three pulses, 3, 4, 5, each 1 cycle after its input.
- Change k from 2 to 1 after the 2nd sample of a window, samples 4, 8, 12, 16, 20, 30 → results 10, then 25.
- restart after 3 of 4 samples (k=2) with a coincident sample 50, then 50, 50, 50 → no pulse for the partial window, then sample_out=50. Repeat with rst instead of restart: no pulse, outputs forced to 0.
